hazard_ctrl_flow: RTL and testbench

- Parametrised control-flow hazard unit for the RISC-V pipeline; successor to the fixed two-cycle jump stall.
- Decodes B-type, JAL and JALR in the fetch/decode instruction word and holds the pipeline for a per-class programmable number of cycles.
- Adds taken/not-taken resolution feedback from EX: a one-cycle IF flush pulse, and optional early release of not-taken branch stalls.
- Sits between the IF/ID register and the pipeline-register enables.

---
 rtl/hazard_ctrl_flow_pkg.sv | 24 ++
 rtl/cf_inst_classify.sv | 29 ++
 rtl/hazard_ctrl_flow.sv | 139 +++++++++++++
 tb/tb_hazard_ctrl_flow.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_flow_pkg.sv
// Shared encodings for the control-flow hazard unit and its classifier.
//   OPC_*      : RISC-V major opcodes (inst[6:0]) that redirect the PC
//   cf_class_e : control-flow class of the decode-stage instruction
//   hz_state_e : hazard FSM states
package hazard_ctrl_flow_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    CF_NONE = 2'b00,
    CF_BR   = 2'b01,
    CF_JAL  = 2'b10,
    CF_JALR = 2'b11
  } cf_class_e;

  typedef enum logic [1:0] {
    HZ_IDLE    = 2'b00,
    HZ_STALL   = 2'b01,
    HZ_RELEASE = 2'b10
  } hz_state_e;

endpackage

// File: rtl/cf_inst_classify.sv
// Combinational control-flow classifier.
//   inst_i       : instruction word (only the major opcode is decoded)
//   inst_valid_i : 0 = bubble, forces CF_NONE
//   class_o      : CF_NONE / CF_BR / CF_JAL / CF_JALR
module cf_inst_classify
  import hazard_ctrl_flow_pkg::*;
(
  input  logic [31:0] inst_i,
  input  logic        inst_valid_i,
  output cf_class_e   class_o
);

  // Fields above the opcode play no part in classification.
  logic unused_inst_hi;
  assign unused_inst_hi = ^inst_i[31:7];

  always_comb begin
    class_o = CF_NONE;
    if (inst_valid_i) begin
      case (inst_i[6:0])
        OPC_BRANCH: class_o = CF_BR;
        OPC_JAL:    class_o = CF_JAL;
        OPC_JALR:   class_o = CF_JALR;
        default:    class_o = CF_NONE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl_flow.sv
// Control-flow hazard unit: holds PC and IF/ID for a per-class number of
// cycles after a branch/jal/jalr reaches decode, pulses flush_if after a
// taken resolution from EX, and optionally ends a branch stall early on a
// not-taken resolution.
//   clk, rst           : clock, asynchronous active-high reset
//   inst, inst_valid   : decode-stage instruction and its valid flag
//   ex_resolve/ex_taken: EX resolution of the pending control-flow inst
//   pipeline_stop_jump : stall to PC and IF/ID enables
//   flush_if           : one-cycle squash of IF/ID
//   active_class       : class being stalled (00 when not stalling)
//   stall_remaining    : stall cycles left after the current one
module hazard_ctrl_flow
  import hazard_ctrl_flow_pkg::*;
#(
  parameter int BR_STALL      = 2,
  parameter int JAL_STALL     = 2,
  parameter int JALR_STALL    = 2,
  parameter int CNT_W         = 3,
  parameter bit EARLY_RELEASE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             inst_valid,
  input  logic             ex_resolve,
  input  logic             ex_taken,
  output logic             pipeline_stop_jump,
  output logic             flush_if,
  output logic [1:0]       active_class,
  output logic [CNT_W-1:0] stall_remaining
);

  if (CNT_W < 1 || BR_STALL > (1 << CNT_W) || JAL_STALL > (1 << CNT_W) ||
      JALR_STALL > (1 << CNT_W) || BR_STALL < 0 || JAL_STALL < 0 ||
      JALR_STALL < 0) begin : g_bad_params
    $error("hazard_ctrl_flow: illegal stall/counter parameters");
  end

  // Stall lengths may equal 2**CNT_W, so they need one extra bit.
  localparam logic [CNT_W:0] BR_N   = (CNT_W+1)'(BR_STALL);
  localparam logic [CNT_W:0] JAL_N  = (CNT_W+1)'(JAL_STALL);
  localparam logic [CNT_W:0] JALR_N = (CNT_W+1)'(JALR_STALL);
  localparam logic [CNT_W:0] ONE_N  = (CNT_W+1)'(1);

  cf_class_e        cls_w;
  logic [CNT_W:0]   n_w;
  logic [CNT_W:0]   n_m1_w;

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cf_class_e        cls_q, cls_d;
  logic             resd_q, resd_d;   // a resolve was already seen this stall
  logic             flush_q, flush_d;
  logic             first_res;
  logic             early;

  cf_inst_classify u_classify (
    .inst_i       (inst),
    .inst_valid_i (inst_valid),
    .class_o      (cls_w)
  );

  always_comb begin
    n_w = '0;
    case (cls_w)
      CF_BR:   n_w = BR_N;
      CF_JAL:  n_w = JAL_N;
      CF_JALR: n_w = JALR_N;
      default: n_w = '0;
    endcase
  end

  assign n_m1_w = n_w - ONE_N;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cls_d     = cls_q;
    resd_d    = resd_q;
    flush_d   = 1'b0;
    first_res = 1'b0;
    early     = 1'b0;
    case (state_q)
      HZ_IDLE: begin
        if (cls_w != CF_NONE && n_w != '0) begin
          state_d = HZ_STALL;
          cnt_d   = n_m1_w[CNT_W-1:0];
          cls_d   = cls_w;
          resd_d  = 1'b0;
        end
      end
      HZ_STALL: begin
        first_res = ex_resolve && !resd_q;
        if (ex_resolve) resd_d = 1'b1;
        flush_d = first_res && ex_taken;
        early   = first_res && !ex_taken && EARLY_RELEASE && (cls_q == CF_BR);
        if (cnt_q == '0 || early) begin
          state_d = HZ_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HZ_RELEASE: begin
        // Stalled instruction is still in decode: no detection here.
        state_d = HZ_IDLE;
        cls_d   = CF_NONE;
      end
      default: begin
        state_d = HZ_IDLE;
        cnt_d   = '0;
        cls_d   = CF_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HZ_IDLE;
      cnt_q   <= '0;
      cls_q   <= CF_NONE;
      resd_q  <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      resd_q  <= resd_d;
      flush_q <= flush_d;
    end
  end

  // Outputs decode flops only.
  assign pipeline_stop_jump = (state_q == HZ_STALL);
  assign active_class       = (state_q == HZ_STALL) ? cls_q : CF_NONE;
  assign stall_remaining    = (state_q == HZ_STALL) ? cnt_q : '0;
  assign flush_if           = flush_q;

endmodule

// File: tb/tb_hazard_ctrl_flow.sv
module tb_hazard_ctrl_flow;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = 32'h0000_0013;
  logic        inst_valid = 1'b0;
  logic        ex_resolve = 1'b0;
  logic        ex_taken = 1'b0;

  logic       stop_a, flush_a, stop_b, flush_b;
  logic [1:0] cls_a, cls_b;
  logic [2:0] rem_a, rem_b;

  int n_vec = 0;
  int n_err = 0;

  logic [13:0] exp_q[$];

  // Instance a: defaults. Instance b: longer stalls, JAL unstalled,
  // BR_STALL at the 2**CNT_W boundary, no early release.
  hazard_ctrl_flow u_dut_a (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .ex_resolve(ex_resolve), .ex_taken(ex_taken),
    .pipeline_stop_jump(stop_a), .flush_if(flush_a),
    .active_class(cls_a), .stall_remaining(rem_a)
  );

  hazard_ctrl_flow #(
    .BR_STALL(8), .JAL_STALL(0), .JALR_STALL(4), .CNT_W(3), .EARLY_RELEASE(1'b0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .ex_resolve(ex_resolve), .ex_taken(ex_taken),
    .pipeline_stop_jump(stop_b), .flush_if(flush_b),
    .active_class(cls_b), .stall_remaining(rem_b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int p_br[2]   = '{2, 8};
  int p_jal[2]  = '{2, 0};
  int p_jalr[2] = '{2, 4};
  bit p_er[2]   = '{1'b1, 1'b0};

  int m_left[2];   // stall cycles still to be shown, including the current one
  int m_cls[2];
  bit m_rel[2];
  bit m_resd[2];
  bit m_flush[2];

  function automatic int class_of(logic [31:0] w, logic v);
    logic [6:0] opc;
    opc = w[6:0];
    if (!v) return 0;
    if (opc == 7'h63) return 1;
    if (opc == 7'h6F) return 2;
    if (opc == 7'h67) return 3;
    return 0;
  endfunction

  function automatic int stall_of(int i, int c);
    if (c == 1) return p_br[i];
    if (c == 2) return p_jal[i];
    if (c == 3) return p_jalr[i];
    return 0;
  endfunction

  function automatic logic [6:0] model_out(int i);
    logic [6:0] v;
    v = '0;
    if (m_left[i] > 0) begin
      v[6]   = 1'b1;
      v[4:3] = 2'(m_cls[i]);
      v[2:0] = 3'(m_left[i] - 1);
    end
    v[5] = m_flush[i];
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          m_left[i] = 0; m_cls[i] = 0; m_rel[i] = 0; m_resd[i] = 0; m_flush[i] = 0;
        end else begin
          bit fl;
          fl = 0;
          if (m_left[i] > 0) begin
            if (ex_resolve && !m_resd[i]) begin
              if (ex_taken) fl = 1;
              else if (p_er[i] && m_cls[i] == 1) m_left[i] = 1;
            end
            if (ex_resolve) m_resd[i] = 1;
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) m_rel[i] = 1;
          end else if (m_rel[i]) begin
            m_rel[i] = 0;
          end else begin
            int c, n;
            c = class_of(inst, inst_valid);
            n = stall_of(i, c);
            if (c != 0 && n > 0) begin
              m_left[i] = n; m_cls[i] = c; m_resd[i] = 0;
            end
          end
          m_flush[i] = fl;
        end
      end
      exp_q.push_back({model_out(0), model_out(1)});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      begin
        logic [13:0] act, e;
        act = {stop_a, flush_a, cls_a, rem_a, stop_b, flush_b, cls_b, rem_b};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard_empty t=%0t got=%h want=<entry>", $time, act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            n_err++;
            $display("FAIL outputs t=%0t got a=%b b=%b want a=%b b=%b",
                     $time, act[13:7], act[6:0], e[13:7], e[6:0]);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  localparam logic [31:0] I_BEQ  = 32'h0020_8463;
  localparam logic [31:0] I_BNE  = 32'h0020_9463;
  localparam logic [31:0] I_JAL  = 32'h0100_00EF;
  localparam logic [31:0] I_JALR = 32'h0000_80E7;
  localparam logic [31:0] I_ADD  = 32'h0020_81B3;
  localparam logic [31:0] I_ADDI = 32'h0010_0093;

  task automatic cyc(input logic [31:0] w, input logic v, input logic res, input logic tk);
    inst = w; inst_valid = v; ex_resolve = res; ex_taken = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(I_ADD, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // single BEQ held four cycles, no resolve
    for (int k = 0; k < 4; k++) cyc(I_BEQ, 1'b1, 1'b0, 1'b0);
    idle(10);

    // JALR, taken resolve in stall cycle 2
    cyc(I_JALR, 1'b1, 1'b0, 1'b0);
    cyc(I_JALR, 1'b1, 1'b0, 1'b0);
    cyc(I_JALR, 1'b1, 1'b1, 1'b1);
    cyc(I_JALR, 1'b1, 1'b1, 1'b1);   // second resolve must be ignored
    cyc(I_JALR, 1'b1, 1'b0, 1'b0);
    idle(6);

    // BNE, not-taken resolve in stall cycle 1
    cyc(I_BNE, 1'b1, 1'b0, 1'b0);
    cyc(I_BNE, 1'b1, 1'b1, 1'b0);
    cyc(I_BNE, 1'b1, 1'b0, 1'b0);
    idle(10);

    // JAL followed by back-to-back ADDs
    cyc(I_JAL, 1'b1, 1'b0, 1'b0);
    idle(4);

    // resolves while idle are ignored
    cyc(I_ADD, 1'b1, 1'b1, 1'b1);
    cyc(I_ADD, 1'b1, 1'b1, 1'b0);

    // branch, non-jump, invalid branch, branch
    cyc(I_BEQ, 1'b1, 1'b0, 1'b0);
    cyc(I_ADDI, 1'b1, 1'b0, 1'b0);
    cyc(I_BEQ, 1'b0, 1'b0, 1'b0);
    cyc(I_BNE, 1'b1, 1'b0, 1'b0);
    cyc(I_BNE, 1'b1, 1'b0, 1'b0);
    cyc(I_BNE, 1'b1, 1'b0, 1'b0);
    cyc(I_BNE, 1'b1, 1'b0, 1'b0);
    idle(10);

    // asynchronous reset mid-stall
    cyc(I_BEQ, 1'b1, 1'b0, 1'b0);
    cyc(I_ADD, 1'b1, 1'b0, 1'b0);      // now in stall cycle 1
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({stop_a, flush_a, cls_a, rem_a, stop_b, flush_b, cls_b, rem_b} !== 14'b0) begin
      n_err++;
      $display("FAIL async_reset got a=%b%b%b%b b=%b%b%b%b want all zero",
               stop_a, flush_a, cls_a, rem_a, stop_b, flush_b, cls_b, rem_b);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    idle(4);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic [31:0] w;
      int sel;
      w = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0: w[6:0] = 7'h63;
        1: w[6:0] = 7'h6F;
        2: w[6:0] = 7'h67;
        3: w[6:0] = 7'h13;
        4: w[6:0] = 7'h33;
        default: ;
      endcase
      cyc(w, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
    idle(12);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
